// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the committed-store buffer and its load forwarding.
package store_buffer_pkg;

  localparam int DEPTH     = 8;
  localparam int DEPTH_LOG = $clog2(DEPTH);

  typedef enum logic [2:0] {
    BYTE   = 3'd0,
    HALF   = 3'd1,
    WORD   = 3'd2,
    BYTE_U = 3'd3,
    HALF_U = 3'd4
  } ldst_mode;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    ldst_mode    mode;
  } sb_entry;

  // Byte lanes of the aligned word touched by an access of this width at this offset.
  function automatic logic [3:0] byte_mask(ldst_mode mode, logic [1:0] offs);
    case (mode)
      BYTE, BYTE_U: byte_mask = 4'b0001 << offs;
      HALF, HALF_U: byte_mask = offs[1] ? 4'b1100 : 4'b0011;
      WORD:         byte_mask = 4'b1111;
      default:      byte_mask = 4'b0000;
    endcase
  endfunction

  // Store data arrives low-aligned; move it onto the lanes it will occupy in memory.
  function automatic logic [31:0] lane_data(logic [31:0] data, logic [1:0] offs);
    lane_data = data << {offs, 3'b000};
  endfunction

endpackage

// File: rtl/sb_forward.sv
// Per-load-port forwarding: merges buffered/incoming store bytes over the memory word,
// then extracts and extends the addressed field.
module sb_forward
  import store_buffer_pkg::*;
(
  input  sb_entry              entries [DEPTH],
  input  logic [DEPTH-1:0]     valid,
  input  logic [DEPTH_LOG-1:0] head,
  input  logic [DEPTH_LOG-1:0] tail,
  input  logic                 st_we,
  input  sb_entry              st_entry,
  input  logic [31:0]          ld_addr,
  input  ldst_mode             ld_mode,
  input  logic [31:0]          mem_rd,
  output logic [31:0]          ld_data
);

  logic [31:0]          merged;
  logic [31:0]          shifted;
  logic [31:0]          lane;
  logic [3:0]           mask;
  logic [3:0]           taken;
  logic [DEPTH_LOG-1:0] idx;
  logic                 past_head;

  // Youngest-first byte merge: incoming store, then entries walking back from tail to head.
  always_comb begin
    merged    = mem_rd;
    taken     = 4'b0000;
    past_head = 1'b0;
    idx       = tail;
    mask      = byte_mask(st_entry.mode, st_entry.addr[1:0]);
    lane      = lane_data(st_entry.data, st_entry.addr[1:0]);
    if (st_we && (st_entry.addr[31:2] == ld_addr[31:2])) begin
      for (int b = 0; b < 4; b++) begin
        if (mask[b]) begin
          merged[8*b +: 8] = lane[8*b +: 8];
          taken[b]         = 1'b1;
        end
      end
    end
    for (int k = 1; k <= DEPTH; k++) begin
      idx = tail - DEPTH_LOG'(k);
      if (valid[idx] && !past_head && (entries[idx].addr[31:2] == ld_addr[31:2])) begin
        mask = byte_mask(entries[idx].mode, entries[idx].addr[1:0]);
        lane = lane_data(entries[idx].data, entries[idx].addr[1:0]);
        for (int b = 0; b < 4; b++) begin
          if (mask[b] && !taken[b]) begin
            merged[8*b +: 8] = lane[8*b +: 8];
            taken[b]         = 1'b1;
          end
        end
      end
      // head is the oldest live slot; nothing behind it belongs to the queue
      if (idx == head) past_head = 1'b1;
    end
  end

  // Align the addressed field to bit 0 and extend per load mode.
  always_comb begin
    shifted = merged >> {ld_addr[1:0], 3'b000};
    case (ld_mode)
      BYTE:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      HALF:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      BYTE_U:  ld_data = {24'd0, shifted[7:0]};
      HALF_U:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Committed-store queue: accepts one retired store per cycle, drains in order to a
// stallable memory write port, and forwards pending bytes to both load ports.
module store_buffer
  import store_buffer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        st_we,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  ldst_mode    st_mode,
  output logic        full,
  output logic        overflow,
  input  logic [31:0] ld_addr [2],
  input  ldst_mode    ld_mode [2],
  output logic [31:0] ld_data [2],
  output logic [31:0] mem_ra  [2],
  input  logic [31:0] mem_rd  [2],
  output logic        mem_we,
  output logic [31:0] mem_wa,
  output logic [31:0] mem_wd,
  output ldst_mode    mem_wm,
  input  logic        mem_ready
);

  localparam int CW = DEPTH_LOG + 1;

  sb_entry              entries [DEPTH];
  logic [DEPTH-1:0]     valid;
  logic [DEPTH-1:0]     valid_nxt;
  logic [DEPTH_LOG-1:0] head;
  logic [DEPTH_LOG-1:0] tail;
  logic [CW-1:0]        count;
  logic                 push;
  logic                 pop;
  sb_entry              st_entry;

  assign st_entry = '{addr: st_addr, data: st_data, mode: st_mode};
  assign full     = (count == CW'(DEPTH));
  assign mem_we   = (count != '0);
  assign pop      = mem_we && mem_ready;
  // a full buffer still takes a store when the head leaves in the same cycle
  assign push     = st_we && (!full || pop);
  assign mem_wa   = entries[head].addr;
  assign mem_wd   = entries[head].data;
  assign mem_wm   = entries[head].mode;

  // Clear the departing slot before marking the arriving one; they coincide when full.
  always_comb begin
    valid_nxt = valid;
    if (pop)  valid_nxt[head] = 1'b0;
    if (push) valid_nxt[tail] = 1'b1;
  end

  // Queue pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      valid    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop)  head <= head + 1'b1;
      if (push) tail <= tail + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      valid <= valid_nxt;
      if (st_we && full && !pop) overflow <= 1'b1;
    end
  end

  // Entry payload; liveness is tracked by valid, so contents need no reset.
  always_ff @(posedge clk) begin
    if (push) entries[tail] <= st_entry;
  end

  for (genvar p = 0; p < 2; p++) begin : g_ld
    assign mem_ra[p] = {ld_addr[p][31:2], 2'b00};

    sb_forward u_fwd (
      .entries  (entries),
      .valid    (valid),
      .head     (head),
      .tail     (tail),
      .st_we    (st_we),
      .st_entry (st_entry),
      .ld_addr  (ld_addr[p]),
      .ld_mode  (ld_mode[p]),
      .mem_rd   (mem_rd[p]),
      .ld_data  (ld_data[p])
    );
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a scoreboard of expected memory writes.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_we;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  ldst_mode    st_mode;
  logic        full;
  logic        overflow;
  logic [31:0] ld_addr [2];
  ldst_mode    ld_mode [2];
  logic [31:0] ld_data [2];
  logic [31:0] mem_ra  [2];
  logic [31:0] mem_rd  [2];
  logic        mem_we;
  logic [31:0] mem_wa;
  logic [31:0] mem_wd;
  ldst_mode    mem_wm;
  logic        mem_ready;

  int      vectors     = 0;
  int      miscompares = 0;
  sb_entry sbq[$];
  sb_entry popped;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .st_we     (st_we),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_mode   (st_mode),
    .full      (full),
    .overflow  (overflow),
    .ld_addr   (ld_addr),
    .ld_mode   (ld_mode),
    .ld_data   (ld_data),
    .mem_ra    (mem_ra),
    .mem_rd    (mem_rd),
    .mem_we    (mem_we),
    .mem_wa    (mem_wa),
    .mem_wd    (mem_wd),
    .mem_wm    (mem_wm),
    .mem_ready (mem_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input ldst_mode m,
                       input bit track);
    st_we   = 1'b1;
    st_addr = a;
    st_data = d;
    st_mode = m;
    if (track) sbq.push_back('{addr: a, data: d, mode: m});
  endtask

  task automatic idle();
    st_we = 1'b0;
  endtask

  // Every cycle the drain port is active, its fields must match the oldest expected store;
  // this also covers stability across stall cycles.
  always @(negedge clk) begin
    if (reset === 1'b1 && mem_we === 1'b1) begin
      if (sbq.size() == 0) begin
        check("drain_unexpected", 32'(mem_we), 32'd0);
      end else begin
        check("mem_wa", mem_wa, sbq[0].addr);
        check("mem_wd", mem_wd, sbq[0].data);
        check("mem_wm", 32'(mem_wm), 32'(sbq[0].mode));
        if (mem_ready) popped = sbq.pop_front();
      end
    end
  end

  initial begin
    reset = 1'b0; st_we = 1'b0; st_addr = '0; st_data = '0; st_mode = WORD; mem_ready = 1'b0;
    for (int p = 0; p < 2; p++) begin
      ld_addr[p] = '0; ld_mode[p] = WORD; mem_rd[p] = '0;
    end
    #2;
    check("rst_full",     32'(full),      32'd0);
    check("rst_mem_we",   32'(mem_we),    32'd0);
    check("rst_overflow", 32'(overflow),  32'd0);
    check("rst_count",    32'(dut.count), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tick();

    // 1: reset while three stores are stalled in the queue
    store(32'h10, 32'h1, WORD, 1); tick();
    store(32'h14, 32'h2, WORD, 1); tick();
    store(32'h18, 32'h3, WORD, 1); tick();
    idle();
    sample();
    check("t1_count_before", 32'(dut.count), 32'd3);
    check("t1_mem_we_before", 32'(mem_we), 32'd1);
    tick();
    #1 reset = 1'b0;
    sbq.delete();
    #1;
    check("t1_count",  32'(dut.count), 32'd0);
    check("t1_mem_we", 32'(mem_we),    32'd0);
    check("t1_full",   32'(full),      32'd0);
    #1 reset = 1'b1;
    tick();

    // 2: forwarding with byte merge and extension
    store(32'h100, 32'hDEADBEEF, WORD, 1); tick();
    store(32'h101, 32'h55, BYTE, 1); tick();
    idle();
    ld_addr[0] = 32'h100; ld_mode[0] = WORD;
    ld_addr[1] = 32'h101; ld_mode[1] = BYTE;
    sample();
    check("t2_word",   ld_data[0], 32'hDEAD55EF);
    check("t2_byte",   ld_data[1], 32'h00000055);
    check("t2_mem_ra", mem_ra[1],  32'h00000100);
    tick();
    ld_addr[0] = 32'h103; ld_mode[0] = BYTE_U;
    ld_addr[1] = 32'h102; ld_mode[1] = HALF;
    sample();
    check("t2_byte_u", ld_data[0], 32'h000000DE);
    check("t2_half",   ld_data[1], 32'hFFFFDEAD);
    tick();
    mem_rd[0] = 32'hAB000000;
    ld_addr[1] = 32'h104; ld_mode[1] = BYTE; mem_rd[1] = 32'h12345680;
    sample();
    check("t2_byte_u_over_mem", ld_data[0], 32'h000000DE);
    check("t2_mem_only",        ld_data[1], 32'hFFFFFF80);
    tick();
    mem_ready = 1'b1;
    mem_rd[0] = '0; mem_rd[1] = '0;
    repeat (3) tick();
    sample();
    check("t2_drained", 32'(mem_we), 32'd0);
    tick();

    // 3: same-cycle bypass from the incoming store
    store(32'h202, 32'h8001, HALF, 1);
    ld_addr[0] = 32'h202; ld_mode[0] = HALF;
    sample();
    check("t3_bypass",     ld_data[0], 32'hFFFF8001);
    check("t3_mem_we_now", 32'(mem_we), 32'd0);
    tick();
    idle();
    sample();
    check("t3_mem_we_next", 32'(mem_we), 32'd1);
    tick();

    // 4: full, push-with-pop, and overflow
    mem_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      store(32'h400 + 32'(4 * i), 32'hA0 + 32'(i), WORD, 1);
      tick();
    end
    idle();
    sample();
    check("t4_full",  32'(full),      32'd1);
    check("t4_count", 32'(dut.count), 32'd8);
    tick();
    mem_ready = 1'b1;
    store(32'h500, 32'h55AA, WORD, 1);
    sample();
    check("t4_full_pushpop", 32'(full), 32'd1);
    tick();
    idle();
    mem_ready = 1'b0;
    sample();
    check("t4_count_pushpop", 32'(dut.count), 32'd8);
    check("t4_no_overflow",   32'(overflow),  32'd0);
    tick();
    store(32'h600, 32'hBAD, WORD, 0);
    tick();
    idle();
    sample();
    check("t4_overflow",       32'(overflow),  32'd1);
    check("t4_count_dropped",  32'(dut.count), 32'd8);
    tick();
    mem_ready = 1'b1;
    repeat (10) tick();
    sample();
    check("t4_drained",         32'(mem_we),     32'd0);
    check("t4_sb_empty",        32'(sbq.size()), 32'd0);
    check("t4_overflow_sticky", 32'(overflow),   32'd1);
    tick();
    #1 reset = 1'b0;
    sbq.delete();
    #1;
    check("t4_overflow_cleared", 32'(overflow), 32'd0);
    reset = 1'b1;

    // 5: streaming under alternating backpressure with pointer wrap
    for (int i = 0; i < 12; i++) begin
      tick();
      store(32'h700 + 32'(4 * i), $urandom, ldst_mode'(3'(i % 5)), 1);
      mem_ready = (i % 2 == 1);
    end
    tick();
    idle();
    for (int i = 0; i < 30; i++) begin
      mem_ready = (i % 3 != 0);
      tick();
    end
    sample();
    check("t5_sb_empty", 32'(sbq.size()), 32'd0);
    check("t5_drained",  32'(mem_we),     32'd0);
    check("t5_tail",     32'(dut.tail),   32'd4);

    // 6: youngest-first forwarding across the wrap point
    tick();
    mem_ready = 1'b1;
    store(32'h3F0, 32'h1, WORD, 1);
    tick();
    idle();
    repeat (2) tick();
    mem_ready = 1'b0;
    store(32'h310, 32'hCAFEF00D, WORD, 1); tick();
    store(32'h320, 32'h33333333, WORD, 1); tick();
    store(32'h300, 32'h11111111, WORD, 1); tick();
    store(32'h300, 32'h22222222, WORD, 1); tick();
    idle();
    ld_addr[0] = 32'h300; ld_mode[0] = WORD;   mem_rd[0] = 32'h99999999;
    ld_addr[1] = 32'h311; ld_mode[1] = BYTE_U; mem_rd[1] = 32'h99999999;
    sample();
    check("t6_head",       32'(dut.head), 32'd5);
    check("t6_tail",       32'(dut.tail), 32'd1);
    check("t6_youngest",   ld_data[0],    32'h22222222);
    check("t6_byte_after", ld_data[1],    32'h000000F0);
    tick();
    mem_ready = 1'b1;
    repeat (8) tick();
    sample();
    check("t6_sb_empty", 32'(sbq.size()), 32'd0);
    check("t6_drained",  32'(mem_we),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
